// File: rtl/snow3g_keystream_gen.sv
// SNOW 3G keystream generator: 16-word LFSR plus three-register FSM.
// After reset release it runs 32 initialisation rounds and one discarded
// keystream round, then registers one 32-bit keystream word every clock.
//
// Output handshake: keystream_valid is a level, not a pulse. It is low from
// reset until the first word, then stays high and keystream carries a fresh
// word on every clock until the next reset. There is no ready/back-pressure.
module snow3g_keystream_gen (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] s_key,
    input  logic [127:0] IV,
    output logic [31:0]  keystream,
    output logic         keystream_valid
);

    typedef enum logic [1:0] {
        MODE_INIT    = 2'd0,
        MODE_DISCARD = 2'd1,
        MODE_GEN     = 2'd2
    } mode_e;

    // AES S-box SR, indexed by input byte.
    localparam logic [7:0] SR_ROM [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2)[x]/(x^8 + c).
    function automatic logic [7:0] mulx(input logic [7:0] v, input logic [7:0] c);
        mulx = v[7] ? ({v[6:0], 1'b0} ^ c) : {v[6:0], 1'b0};
    endfunction

    // MULx applied n times; the fixed bound keeps the loop static.
    function automatic logic [7:0] mulx_pow(input logic [7:0] v, input int n, input logic [7:0] c);
        logic [7:0] acc;
        acc = v;
        for (int k = 0; k < 255; k++) begin
            if (k < n) acc = mulx(acc, c);
        end
        return acc;
    endfunction

    function automatic logic [31:0] mul_alpha(input logic [7:0] c);
        return {mulx_pow(c, 23, 8'hA9), mulx_pow(c, 245, 8'hA9),
                mulx_pow(c, 48, 8'hA9), mulx_pow(c, 239, 8'hA9)};
    endfunction

    function automatic logic [31:0] div_alpha(input logic [7:0] c);
        return {mulx_pow(c, 16, 8'hA9), mulx_pow(c, 39, 8'hA9),
                mulx_pow(c, 6, 8'hA9), mulx_pow(c, 64, 8'hA9)};
    endfunction

    // Field multiply in GF(2^8) with polynomial x^8+x^6+x^5+x^3+1.
    function automatic logic [7:0] gf_mul_69(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = mulx(aa, 8'h69);
        end
        return p;
    endfunction

    // SQ box from its Dickson-polynomial definition, built with a
    // square-and-multiply chain over the exponents it needs.
    function automatic logic [7:0] sq_box(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x9, x12, x13, x15, x16, x32;
        logic [7:0] x33, x41, x45, x47, x49;
        x2  = gf_mul_69(x, x);
        x4  = gf_mul_69(x2, x2);
        x8  = gf_mul_69(x4, x4);
        x9  = gf_mul_69(x8, x);
        x12 = gf_mul_69(x8, x4);
        x13 = gf_mul_69(x12, x);
        x15 = gf_mul_69(x13, x2);
        x16 = gf_mul_69(x8, x8);
        x32 = gf_mul_69(x16, x16);
        x33 = gf_mul_69(x32, x);
        x41 = gf_mul_69(x32, x9);
        x45 = gf_mul_69(x32, x13);
        x47 = gf_mul_69(x32, x15);
        x49 = gf_mul_69(x47, x2);
        return x ^ x9 ^ x13 ^ x15 ^ x33 ^ x41 ^ x45 ^ x47 ^ x49 ^ 8'h25;
    endfunction

    // MixColumn-style diffusion shared by S1 and S2.
    function automatic logic [31:0] mix_column(input logic [7:0] x0, input logic [7:0] x1,
                                               input logic [7:0] x2, input logic [7:0] x3,
                                               input logic [7:0] c);
        logic [7:0] m0, m1, m2, m3;
        m0 = mulx(x0, c);
        m1 = mulx(x1, c);
        m2 = mulx(x2, c);
        m3 = mulx(x3, c);
        return {m0 ^ x1 ^ x2 ^ m3 ^ x3,
                m0 ^ x0 ^ m1 ^ x2 ^ x3,
                x0 ^ m1 ^ x1 ^ m2 ^ x3,
                x0 ^ x1 ^ m2 ^ m3 ^ x2};
    endfunction

    function automatic logic [31:0] s1_fn(input logic [31:0] w);
        return mix_column(SR_ROM[w[31:24]], SR_ROM[w[23:16]], SR_ROM[w[15:8]], SR_ROM[w[7:0]], 8'h1B);
    endfunction

    function automatic logic [31:0] s2_fn(input logic [31:0] w);
        return mix_column(sq_box(w[31:24]), sq_box(w[23:16]), sq_box(w[15:8]), sq_box(w[7:0]), 8'h69);
    endfunction

    logic [31:0] s_q [16];
    logic [31:0] s_d [16];
    logic [31:0] s_init [16];
    logic [31:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [5:0]  cnt_q, cnt_d;
    mode_e       mode_q, mode_d;
    logic [31:0] ks_q, ks_d;
    logic        ks_valid_q, ks_valid_d;
    logic [31:0] f_w, v_w;

    // Key/IV load image for the LFSR, applied on every clock while in reset.
    always_comb begin
        logic [31:0] k0, k1, k2, k3, iv0, iv1, iv2, iv3;
        k0  = s_key[127:96];
        k1  = s_key[95:64];
        k2  = s_key[63:32];
        k3  = s_key[31:0];
        iv0 = IV[127:96];
        iv1 = IV[95:64];
        iv2 = IV[63:32];
        iv3 = IV[31:0];
        s_init[15] = k3 ^ iv0;
        s_init[14] = k2;
        s_init[13] = k1;
        s_init[12] = k0 ^ iv1;
        s_init[11] = ~k3;
        s_init[10] = ~k2 ^ iv2;
        s_init[9]  = ~k1 ^ iv3;
        s_init[8]  = ~k0;
        s_init[7]  = k3;
        s_init[6]  = k2;
        s_init[5]  = k1;
        s_init[4]  = k0;
        s_init[3]  = ~k3;
        s_init[2]  = ~k2;
        s_init[1]  = ~k1;
        s_init[0]  = ~k0;
    end

    // One SNOW 3G round per clock: FSM update, LFSR shift and mode sequencing.
    always_comb begin
        f_w = (s_q[15] + r1_q) ^ r2_q;
        v_w = {s_q[0][23:0], 8'h00} ^ mul_alpha(s_q[0][31:24]) ^ s_q[2]
            ^ {8'h00, s_q[11][31:8]} ^ div_alpha(s_q[11][7:0]);
        if (mode_q == MODE_INIT) v_w = v_w ^ f_w;

        for (int i = 0; i < 15; i++) s_d[i] = s_q[i + 1];
        s_d[15] = v_w;

        r1_d = r2_q + (r3_q ^ s_q[5]);
        r2_d = s1_fn(r1_q);
        r3_d = s2_fn(r2_q);

        cnt_d      = cnt_q;
        mode_d     = mode_q;
        ks_d       = ks_q;
        ks_valid_d = ks_valid_q;
        case (mode_q)
            MODE_INIT: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) mode_d = MODE_DISCARD;
            end
            MODE_DISCARD: begin
                mode_d = MODE_GEN;
            end
            MODE_GEN: begin
                ks_d       = f_w ^ s_q[0];
                ks_valid_d = 1'b1;
            end
            default: begin
                mode_d = MODE_INIT;
            end
        endcase
    end

    // State registers; reset reloads key/IV and restarts initialisation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q        <= s_init;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_INIT;
            ks_q       <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            ks_q       <= ks_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign keystream       = ks_q;
    assign keystream_valid = ks_valid_q;

endmodule

// File: tb/tb_snow3g_keystream_gen.sv
// Bench for snow3g_keystream_gen: an algebraic reference model predicts each
// word when stimulus is issued; a monitor checks what the DUT presents.
module tb_snow3g_keystream_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] s_key = '0;
    logic [127:0] IV = '0;
    logic [31:0]  keystream;
    logic         keystream_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] kat_q[$];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_ks = '0;
    logic        chk_en = 1'b0;

    // clock / reset block
    always #5 clk = ~clk;

    snow3g_keystream_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_key          (s_key),
        .IV             (IV),
        .keystream      (keystream),
        .keystream_valid(keystream_valid)
    );

    // ---------------- reference model ----------------
    logic [7:0]  sr_tab [256];
    logic [7:0]  sq_tab [256];
    logic [31:0] mula_tab [256];
    logic [31:0] diva_tab [256];
    logic [31:0] m_s [16];
    logic [31:0] m_r1, m_r2, m_r3;
    int          m_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ c) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input logic [7:0] a, input int n, input logic [7:0] c);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gf_mul(r, a, c);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // AES S-box from field inverse plus affine map.
    function automatic logic [7:0] sr_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = (x == 8'h00) ? 8'h00 : gf_pow(x, 254, 8'h1B);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sq_calc(input logic [7:0] x);
        logic [7:0] acc;
        int         e [9];
        e   = '{1, 9, 13, 15, 33, 41, 45, 47, 49};
        acc = 8'h25;
        for (int i = 0; i < 9; i++) acc = acc ^ gf_pow(x, e[i], 8'h69);
        return acc;
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w, input bit use_sq);
        logic [7:0] x [4];
        logic [7:0] m [4];
        logic [7:0] c;
        c = use_sq ? 8'h69 : 8'h1B;
        for (int i = 0; i < 4; i++) begin
            x[i] = use_sq ? sq_tab[w[31 - 8 * i -: 8]] : sr_tab[w[31 - 8 * i -: 8]];
            m[i] = gf_mul(x[i], 8'h02, c);
        end
        return {m[0] ^ x[1] ^ x[2] ^ m[3] ^ x[3],
                m[0] ^ x[0] ^ m[1] ^ x[2] ^ x[3],
                x[0] ^ m[1] ^ x[1] ^ m[2] ^ x[3],
                x[0] ^ x[1] ^ m[2] ^ m[3] ^ x[2]};
    endfunction

    task automatic build_tables();
        logic [7:0] pa [4];
        logic [7:0] pd [4];
        int         ea [4];
        int         ed [4];
        ea = '{23, 245, 48, 239};
        ed = '{16, 39, 6, 64};
        for (int j = 0; j < 4; j++) begin
            pa[j] = gf_pow(8'h02, ea[j], 8'hA9);
            pd[j] = gf_pow(8'h02, ed[j], 8'hA9);
        end
        for (int c = 0; c < 256; c++) begin
            sr_tab[c] = sr_calc(8'(c));
            sq_tab[c] = sq_calc(8'(c));
            for (int j = 0; j < 4; j++) begin
                mula_tab[c][31 - 8 * j -: 8] = gf_mul(8'(c), pa[j], 8'hA9);
                diva_tab[c][31 - 8 * j -: 8] = gf_mul(8'(c), pd[j], 8'hA9);
            end
        end
    endtask

    task automatic model_reset(input logic [127:0] key, input logic [127:0] iv);
        logic [31:0] k [4];
        logic [31:0] v [4];
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127 - 32 * i -: 32];
            v[i] = iv[127 - 32 * i -: 32];
        end
        m_s[15] = k[3] ^ v[0];        m_s[14] = k[2];
        m_s[13] = k[1];               m_s[12] = k[0] ^ v[1];
        m_s[11] = k[3] ^ ones;        m_s[10] = k[2] ^ ones ^ v[2];
        m_s[9]  = k[1] ^ ones ^ v[3]; m_s[8]  = k[0] ^ ones;
        m_s[7]  = k[3];               m_s[6]  = k[2];
        m_s[5]  = k[1];               m_s[4]  = k[0];
        m_s[3]  = k[3] ^ ones;        m_s[2]  = k[2] ^ ones;
        m_s[1]  = k[1] ^ ones;        m_s[0]  = k[0] ^ ones;
        m_r1 = '0; m_r2 = '0; m_r3 = '0;
        m_t = 0;
        exp_valid = 1'b0;
        exp_ks    = '0;
    endtask

    // Rounds 0..31 mix F into the LFSR, round 32 is silent, every later
    // round first emits z = F ^ s0 from the pre-round state.
    task automatic model_step();
        logic [31:0] f, rr, v;
        f = (m_s[15] + m_r1) ^ m_r2;
        if (m_t >= 33) begin
            exp_ks    = f ^ m_s[0];
            exp_valid = 1'b1;
            exp_q.push_back(exp_ks);
        end
        rr   = m_r2 + (m_r3 ^ m_s[5]);
        m_r3 = sbox_word(m_r2, 1'b1);
        m_r2 = sbox_word(m_r1, 1'b0);
        m_r1 = rr;
        v = (m_s[0] << 8) ^ mula_tab[m_s[0][31:24]] ^ m_s[2] ^ (m_s[11] >> 8) ^ diva_tab[m_s[11][7:0]];
        if (m_t < 32) v = v ^ f;
        for (int i = 0; i < 15; i++) m_s[i] = m_s[i + 1];
        m_s[15] = v;
        if (m_t < 1000) m_t++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [127:0] key, input logic [127:0] iv);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL word_not_presented: %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
        rst_n = rst;
        s_key = key;
        IV    = iv;
        if (!rst) model_reset(key, iv);
        else      model_step();
        chk_en = 1'b1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_model(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                n_tests++;
                if (keystream_valid !== exp_valid) begin
                    n_fail++;
                    $display("FAIL valid_flag: got %b, required %b (round %0d)", keystream_valid, exp_valid, m_t);
                end
                if (keystream_valid === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got %h, required no word (round %0d)", keystream, m_t);
                    end else begin
                        e = exp_q.pop_front();
                        if (keystream !== e) begin
                            n_fail++;
                            $display("FAIL keystream_word: got %h, required %h (round %0d)", keystream, e, m_t);
                        end
                        if (kat_q.size() != 0) begin
                            e = kat_q.pop_front();
                            n_tests++;
                            if (keystream !== e) begin
                                n_fail++;
                                $display("FAIL etsi_vector: got %h, required %h", keystream, e);
                            end
                        end
                    end
                end else begin
                    n_tests++;
                    if (keystream !== exp_ks) begin
                        n_fail++;
                        $display("FAIL idle_keystream: got %h, required %h", keystream, exp_ks);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k_etsi, iv_etsi, k_mid, iv_mid, rk, riv;
        k_etsi  = {32'h2BD6459F, 32'h82C5B300, 32'h952C4910, 32'h4881FF48};
        iv_etsi = {32'hEA024714, 32'hAD5C4D84, 32'hDF1F9B25, 32'h1C0BF45F};
        k_mid   = 128'h121afb43474b84c6b557e59d1e0c359b;
        iv_mid  = 128'hb08d861d6ba87f00e04aaa5844c347c5;

        build_tables();
        check_model("mulx_80", gf_mul(8'h80, 8'h02, 8'h1B), 32'h1B);
        check_model("mulxpow_01_8", gf_pow(8'h02, 8, 8'h1B), 32'h1B);
        check_model("s1_zero", sbox_word(32'h0, 1'b0), 32'h63636363);

        // ETSI test set 1
        repeat (2) drive(1'b0, k_etsi, iv_etsi);
        kat_q.delete();
        kat_q.push_back(32'hABEE9704);
        kat_q.push_back(32'h7AC31373);
        repeat (40) drive(1'b1, k_etsi, iv_etsi);

        // long reset hold, then key/IV wiggled freely while running
        rk  = rand128();
        riv = rand128();
        repeat (5) drive(1'b0, rk, riv);
        repeat (45) drive(1'b1, rand128(), rand128());

        // mid-stream single-cycle reset must replay the same words
        drive(1'b0, k_mid, iv_mid);
        repeat (50) drive(1'b1, k_mid, iv_mid);
        drive(1'b0, k_mid, iv_mid);
        repeat (60) drive(1'b1, k_mid, iv_mid);

        // reset at E10 of initialisation, then ETSI vectors again
        drive(1'b0, rand128(), rand128());
        repeat (10) drive(1'b1, k_etsi, iv_etsi);
        drive(1'b0, k_etsi, iv_etsi);
        kat_q.delete();
        kat_q.push_back(32'hABEE9704);
        kat_q.push_back(32'h7AC31373);
        repeat (40) drive(1'b1, k_etsi, iv_etsi);

        // random key/IV runs
        for (int r = 0; r < 3; r++) begin
            rk  = rand128();
            riv = rand128();
            repeat (1 + $urandom_range(0, 3)) drive(1'b0, rk, riv);
            repeat (40 + $urandom_range(0, 10)) drive(1'b1, rk, riv);
        end

        // let the last word be observed, then confirm nothing was left over
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || kat_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d words and %0d vectors pending, required 0", exp_q.size(), kat_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snow3g_keystream_gen.md
Name: snow3g_keystream_gen

Overview:
- SNOW 3G stream-cipher keystream generator, as specified in ETSI/SAGE SNOW 3G Spec Doc 2.
- Takes a 128-bit key and a 128-bit IV, runs the 33-clock initialisation, then emits one 32-bit keystream word per clock.
- Feeds the UEA2/UIA2 confidentiality and integrity wrappers.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset; (re)loads key/IV and restarts initialisation
- s_key  input  128  key; s_key[127:96]=k0, [95:64]=k1, [63:32]=k2, [31:0]=k3
- IV  input  128  IV; IV[127:96]=IV0, [95:64]=IV1, [63:32]=IV2, [31:0]=IV3
- keystream  output  32  registered keystream word z_t
- keystream_valid  output  1  high while keystream holds a valid word

Behaviour:
- State:
  - LFSR s0..s15, 32 bits each.
  - FSM registers R1, R2, R3, 32 bits each.
  - 6-bit round counter.
  - Mode: INIT, DISCARD, GEN.
- One clock = one SNOW 3G round; no stalls.
- Reset (any edge with rst_n=0), every cycle while low:
  - s15=k3^IV0, s14=k2, s13=k1, s12=k0^IV1, s11=k3^1s, s10=k2^1s^IV2, s9=k1^1s^IV3, s8=k0^1s.
  - s7=k3, s6=k2, s5=k1, s4=k0, s3=k3^1s, s2=k2^1s, s1=k1^1s, s0=k0^1s (1s = 0xFFFFFFFF).
  - R1=R2=R3=0, counter=0, mode=INIT, keystream=0, keystream_valid=0.
- s_key and IV are sampled only under reset and ignored afterwards.
- FSM (all modes):
  - F = (s15 + R1 mod 2^32) ^ R2.
  - r = R2 + (R3 ^ s5) mod 2^32.
  - R3<=S2(R2), R2<=S1(R1), R1<=r.
- LFSR feedback:
  - v = (s0<<8) ^ MULa(s0[31:24]) ^ s2 ^ (s11>>8) ^ DIVa(s11[7:0]).
  - INIT additionally XORs F into v.
  - Shift: s_i<=s_{i+1} for i=0..14, s15<=v.
- Alpha tables:
  - MULa(c) = {MULxPOW(c,23,0xA9), MULxPOW(c,245,0xA9), MULxPOW(c,48,0xA9), MULxPOW(c,239,0xA9)}.
  - DIVa(c) = {MULxPOW(c,16,0xA9), MULxPOW(c,39,0xA9), MULxPOW(c,6,0xA9), MULxPOW(c,64,0xA9)}.
  - Implement as 256x32 ROMs or as combinational logic.
- MULx(v,c): (v<<1)^c if v[7], else v<<1 (8-bit). MULxPOW(v,i,c) applies MULx i times.
- S-boxes:
  - S1 uses the AES S-box SR with reduction constant 0x1B. S2 uses the SNOW 3G SQ box with constant 0x69.
  - Input bytes w0 (MSB) to w3; x_i = box(w_i); M = MULx(.,const).
  - out0 = M(x0)^x1^x2^M(x3)^x3.
  - out1 = M(x0)^x0^M(x1)^x2^x3.
  - out2 = x0^M(x1)^x1^M(x2)^x3.
  - out3 = x0^x1^M(x2)^M(x3)^x2.
- Sequencing, with edge E0 the first edge where rst_n=1:
  - E0..E31: INIT rounds (32). Counter increments; after E31, mode=DISCARD.
  - E32: one keystream-mode round (no F feedback); output discarded; mode->GEN.
  - E33 onward, each edge: keystream<=F^s0 computed from pre-edge state, keystream_valid<=1, then a keystream-mode round.
  - z1 is visible after E33, z2 after E34, and so on.
- Generation is continuous; keystream never stops until reset.
- Reset asserted mid-initialisation or mid-generation aborts immediately at that edge (reset dominates) and restarts from the current s_key/IV.
- All additions are mod 2^32 with carry discarded.
- Target is 120-400 lines of RTL. The AES S-box and SQ tables are 256-entry case ROMs.

Test Plan:
- ETSI test set 1: key words 2BD6459F 82C5B300 952C4910 4881FF48, IV words EA024714 AD5C4D84 DF1F9B25 1C0BF45F, release reset -> keystream_valid=0 through E32; after E33 keystream=ABEE9704, after E34 keystream=7AC31373.
- Reset hold: rst_n=0 for 5 cycles with any key -> keystream=0, keystream_valid=0 every cycle; first valid word appears exactly 34 edges after release.
- Mid-stream reset: set s_key=121afb43474b84c6b557e59d1e0c359b and IV=b08d861d6ba87f00e04aaa5844c347c5, run 50 cycles, pulse rst_n low for 1 cycle -> the word sequence after restart is identical to the first run, word for word.
- Key change without reset: alter s_key/IV during GEN -> the output sequence is unaffected.
- Reset during INIT at E10: reload ETSI set 1 -> z1=ABEE9704 appears 34 edges after the new release.
- Primitive unit checks:
  - MULx(0x80,0x1B) = 0x1B.
  - MULxPOW(0x01,8,0x1B) = 0x1B.
  - S1(0x00000000) = 0x63636363.
